data_memory_lsu: RTL
====================

// Module: data_memory_lsu
// PURPOSE
//   Load/store unit sitting directly upstream of the data memory bus. Takes one
//   core request (byte/half/word, load/store) via valid/ready and drives the
//   32-bit word-addressed bus (address, write_data, byte_enable, read/write_enable).
//   It lane-aligns stores and extracts/extends loads. Misaligned accesses are
//   split into two word beats. Returns one response pulse per request.
// PARAMETERS
//   DATA_BEGIN  32'h0001_0000  lowest legal byte address
//   DATA_END    32'h0001_FFFF  highest legal byte address
//   ALLOW_SPLIT 1              1: misaligned split into 2 beats; 0: misaligned -> error
// PORTS
//   clock            in   1   single clock, rising edge
//   reset            in   1   asynchronous, active-high
//   req_valid        in   1   request offered
//   req_ready        out  1   1 only in IDLE
//   req_write        in   1   1 store, 0 load
//   req_addr         in   32  byte address
//   req_size         in   2   00 byte, 01 half, 10 word (11 -> error)
//   req_unsigned     in   1   loads: zero-extend if 1, else sign-extend
//   req_wdata        in   32  store data, right-justified
//   rsp_valid        out  1   one-cycle response pulse
//   rsp_rdata        out  32  load result (0 for stores/errors)
//   rsp_error        out  1   out-of-range, illegal size, or misaligned with ALLOW_SPLIT=0
//   bus_address      out  32  word-aligned (bits[1:0]=0)
//   bus_write_data   out  32  lane-aligned store data, unused lanes 0
//   bus_byte_enable  out  4   active lanes of current beat
//   bus_read_enable  out  1
//   bus_write_enable out  1
//   bus_read_data    in   32  synchronous read: valid the cycle after address issued
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except req_ready=1.
// - Bus outputs come only from state + latched request regs; no comb path from req_*.
// - Accept on req_valid && req_ready at edge T; req_* latched; req_valid ignored while busy.
// - States: IDLE -> ISSUE0 -> [CAPT0] -> [ISSUE1 -> [CAPT1]] -> RESP -> IDLE; error: IDLE -> RESP.
// - ISSUE beats: address and enables driven for one cycle; stores assert bus_write_enable there only.
// - CAPT states (loads only): same address/read_enable held; bus_read_data sampled at end of cycle.
// - Offset o = addr[1:0]. Lanes: byte 1<<o; half 0011<<o; word 1111<<o.
//   Bits shifted past lane 3 go to beat 1 at word address +4, low lanes first.
// - Split iff half with o=3 or word with o!=0.
//   Beat0 address = addr & ~3; beat1 address = beat0 address + 4.
// - Range check at accept covers first and last byte (addr .. addr+size-1).
//   Any byte outside [DATA_BEGIN, DATA_END] -> error, no bus enables ever asserted.
// - Load result: beats reassembled little-endian, right-justified. Byte/half sign- or
//   zero-extended per req_unsigned; word ignores req_unsigned.
// - RESP: rsp_valid=1 exactly one cycle; rsp_rdata/rsp_error held stable until the next RESP.
// - Latency after accept edge T: error rsp T+1; aligned store T+2; split store T+3;
//   aligned load T+3; split load T+5. Next accept no earlier than the cycle after RESP.
// - Reset mid-operation: abort immediately, no further beats, no response.
//   Bytes already written by an issued beat stay written.
// TESTING
// 1 Store word 0xDEADBEEF @DATA_BEGIN+8 -> be=1111 addr +8, rsp T+2;
//   load word same -> rsp_rdata 0xDEADBEEF at T+3.
// 2 Mem byte @DATA_BEGIN+1 = 0x80; load byte signed -> 0xFFFFFF80; unsigned -> 0x00000080.
// 3 Store word 0x11223344 @DATA_BEGIN+0x0E -> beat0 addr +0x0C be=1100 wdata 0x33440000;
//   beat1 addr +0x10 be=0011 wdata 0x00001122; load back -> 0x11223344 at T+5.
// 4 Load word @DATA_END-1 (straddles end) and store byte @DATA_END+1 -> rsp_error=1 at T+1,
//   no read/write enable seen.
// 5 Assert reset in ISSUE1 of test-3 store -> outputs 0, no rsp_valid, only beat0 lanes changed;
//   req_ready=1 after release.
// 6 Hold req_valid high for 10 cycles with an aligned load -> exactly one accept per IDLE visit;
//   rsp_valid pulses one cycle each.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Load/store unit between the core and a word-addressed data bus: aligns stores, extracts loads,
// splits misaligned accesses into two beats; response 1-5 cycles after accept, req_ready only in IDLE.
module data_memory_lsu #(
  parameter logic [31:0] DATA_BEGIN  = 32'h0001_0000,
  parameter logic [31:0] DATA_END    = 32'h0001_FFFF,
  parameter bit          ALLOW_SPLIT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic [31:0] bus_read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE0, S_CAPT0, S_ISSUE1, S_CAPT1, S_RESP
  } state_t;

  state_t      st_q, st_d;
  logic        wr_q, wr_d;
  logic        uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        split_q, split_d;
  logic [31:0] addr0_q, addr0_d;
  logic [7:0]  be_q, be_d;
  logic [63:0] wd_q, wd_d;
  logic [31:0] lo_q, lo_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] bus_address_q, bus_address_d;
  logic [31:0] bus_write_data_q, bus_write_data_d;
  logic [3:0]  bus_byte_enable_q, bus_byte_enable_d;
  logic        bus_read_enable_q, bus_read_enable_d;
  logic        bus_write_enable_q, bus_write_enable_d;

  logic [1:0]  off_in;
  logic [2:0]  nbytes_in;
  logic [3:0]  lanes_in;
  logic [31:0] wsel_in;
  logic [7:0]  mask_in;
  logic [63:0] wide_in;
  logic        split_in;
  logic [32:0] last_in;
  logic        err_in;

  // Pair holds {beat1, beat0}; shifting by the byte offset right-justifies the access.
  function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                          input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = 32'(pair >> {off, 3'b000});
    case (size)
      2'b00:   extract = {{24{s[7] & ~uns}}, s[7:0]};
      2'b01:   extract = {{16{s[15] & ~uns}}, s[15:0]};
      default: extract = s;
    endcase
  endfunction

  always_comb begin
    off_in = req_addr[1:0];
    case (req_size)
      2'b00: begin
        nbytes_in = 3'd1;
        lanes_in  = 4'b0001;
        wsel_in   = {24'b0, req_wdata[7:0]};
      end
      2'b01: begin
        nbytes_in = 3'd2;
        lanes_in  = 4'b0011;
        wsel_in   = {16'b0, req_wdata[15:0]};
      end
      2'b10: begin
        nbytes_in = 3'd4;
        lanes_in  = 4'b1111;
        wsel_in   = req_wdata;
      end
      default: begin
        nbytes_in = 3'd1;
        lanes_in  = 4'b0000;
        wsel_in   = 32'b0;
      end
    endcase
    mask_in  = {4'b0000, lanes_in} << off_in;
    wide_in  = {32'b0, wsel_in} << {off_in, 3'b000};
    split_in = (req_size == 2'b01 && off_in == 2'b11) || (req_size == 2'b10 && off_in != 2'b00);
    // 33-bit so an access wrapping past 2^32 still counts as beyond DATA_END.
    last_in  = {1'b0, req_addr} + {30'b0, nbytes_in} - 33'd1;
    err_in   = (req_size == 2'b11) || (req_addr < DATA_BEGIN) || (last_in > {1'b0, DATA_END}) ||
               (split_in && !ALLOW_SPLIT);
  end

  always_comb begin
    st_d        = st_q;
    wr_d        = wr_q;
    uns_d       = uns_q;
    size_d      = size_q;
    off_d       = off_q;
    split_d     = split_q;
    addr0_d     = addr0_q;
    be_d        = be_q;
    wd_d        = wd_q;
    lo_d        = lo_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    case (st_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          uns_d   = req_unsigned;
          size_d  = req_size;
          off_d   = off_in;
          split_d = split_in;
          addr0_d = {req_addr[31:2], 2'b00};
          be_d    = mask_in;
          wd_d    = wide_in;
          if (err_in) begin
            st_d        = S_RESP;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 32'b0;
          end else begin
            st_d = S_ISSUE0;
          end
        end
      end
      S_ISSUE0: begin
        if (!wr_q) begin
          st_d = S_CAPT0;
        end else if (split_q) begin
          st_d = S_ISSUE1;
        end else begin
          st_d        = S_RESP;
          rsp_error_d = 1'b0;
          rsp_rdata_d = 32'b0;
        end
      end
      S_CAPT0: begin
        lo_d = bus_read_data;
        if (split_q) begin
          st_d = S_ISSUE1;
        end else begin
          st_d        = S_RESP;
          rsp_error_d = 1'b0;
          rsp_rdata_d = extract({32'b0, bus_read_data}, off_q, size_q, uns_q);
        end
      end
      S_ISSUE1: begin
        if (wr_q) begin
          st_d        = S_RESP;
          rsp_error_d = 1'b0;
          rsp_rdata_d = 32'b0;
        end else begin
          st_d = S_CAPT1;
        end
      end
      S_CAPT1: begin
        st_d        = S_RESP;
        rsp_error_d = 1'b0;
        rsp_rdata_d = extract({bus_read_data, lo_q}, off_q, size_q, uns_q);
      end
      default: st_d = S_IDLE;
    endcase

    // Outputs are registered versions of what the next state drives.
    req_ready_d        = (st_d == S_IDLE);
    rsp_valid_d        = (st_d == S_RESP);
    bus_address_d      = 32'b0;
    bus_write_data_d   = 32'b0;
    bus_byte_enable_d  = 4'b0;
    bus_read_enable_d  = 1'b0;
    bus_write_enable_d = 1'b0;
    case (st_d)
      S_ISSUE0, S_CAPT0: begin
        bus_address_d     = addr0_d;
        bus_byte_enable_d = be_d[3:0];
        bus_read_enable_d = ~wr_d;
        if (st_d == S_ISSUE0 && wr_d) begin
          bus_write_enable_d = 1'b1;
          bus_write_data_d   = wd_d[31:0];
        end
      end
      S_ISSUE1, S_CAPT1: begin
        bus_address_d     = addr0_d + 32'd4;
        bus_byte_enable_d = be_d[7:4];
        bus_read_enable_d = ~wr_d;
        if (st_d == S_ISSUE1 && wr_d) begin
          bus_write_enable_d = 1'b1;
          bus_write_data_d   = wd_d[63:32];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q               <= S_IDLE;
      wr_q               <= 1'b0;
      uns_q              <= 1'b0;
      size_q             <= 2'b0;
      off_q              <= 2'b0;
      split_q            <= 1'b0;
      addr0_q            <= 32'b0;
      be_q               <= 8'b0;
      wd_q               <= 64'b0;
      lo_q               <= 32'b0;
      req_ready_q        <= 1'b1;
      rsp_valid_q        <= 1'b0;
      rsp_rdata_q        <= 32'b0;
      rsp_error_q        <= 1'b0;
      bus_address_q      <= 32'b0;
      bus_write_data_q   <= 32'b0;
      bus_byte_enable_q  <= 4'b0;
      bus_read_enable_q  <= 1'b0;
      bus_write_enable_q <= 1'b0;
    end else begin
      st_q               <= st_d;
      wr_q               <= wr_d;
      uns_q              <= uns_d;
      size_q             <= size_d;
      off_q              <= off_d;
      split_q            <= split_d;
      addr0_q            <= addr0_d;
      be_q               <= be_d;
      wd_q               <= wd_d;
      lo_q               <= lo_d;
      req_ready_q        <= req_ready_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_rdata_q        <= rsp_rdata_d;
      rsp_error_q        <= rsp_error_d;
      bus_address_q      <= bus_address_d;
      bus_write_data_q   <= bus_write_data_d;
      bus_byte_enable_q  <= bus_byte_enable_d;
      bus_read_enable_q  <= bus_read_enable_d;
      bus_write_enable_q <= bus_write_enable_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_error        = rsp_error_q;
  assign bus_address      = bus_address_q;
  assign bus_write_data   = bus_write_data_q;
  assign bus_byte_enable  = bus_byte_enable_q;
  assign bus_read_enable  = bus_read_enable_q;
  assign bus_write_enable = bus_write_enable_q;

endmodule
